// File: rtl/proc_pkg.sv
// Shared types and defaults for the processing-block memory path.
//   DEF_BITS / DEF_CORES / DEF_ADDR_W : default lane width, lane count and address width
//   arb_state_t                       : memory port arbiter FSM states
//   OP_LOAD / OP_WRITE                : request op encoding carried on req_write
package proc_pkg;

    localparam int DEF_BITS   = 16;
    localparam int DEF_CORES  = 32;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: scans req starting at ptr, wrapping modulo PORTS, and
// returns the first set bit.
//   req     in  PORTS  pending requests
//   ptr     in  IW     highest-priority port index
//   win     out PORTS  one-hot winner (all zero when nothing is pending)
//   win_idx out IW     binary index of the winner
//   any     out 1      at least one request pending
module rr_picker #(
    parameter int PORTS = 4,
    localparam int IW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [PORTS-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    logic found;
    int   idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(ptr) + k) % PORTS;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory load/write port between PORTS processing
// blocks. Requests are arbitrated round-robin and served one at a time; loads
// wait MEM_LATENCY cycles and return the vector on the shared rdata bus.
//   clock, reset          : rising-edge clock, async active-high reset
//   req_valid/write/addr/wdata : per-port request, held until grant (write) or rvalid (load)
//   grant, rvalid         : one-hot pulses (bus access / load data on rdata)
//   rdata                 : last captured load vector, held between loads
//   stall                 : per-port "request pending and not yet complete" (combinational)
//   mem_addr, mem_wdata, mem_load, mem_write : registered memory port
//   mem_rdata             : memory read data, valid MEM_LATENCY cycles after mem_load
module mem_port_arbiter #(
    parameter int PORTS       = 4,
    parameter int CORES       = proc_pkg::DEF_CORES,
    parameter int BITS        = proc_pkg::DEF_BITS,
    parameter int ADDR_W      = proc_pkg::DEF_ADDR_W,
    parameter int MEM_LATENCY = 2,
    localparam int VW = CORES * BITS,
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PORTS-1:0]      req_valid,
    input  logic [PORTS-1:0]      req_write,
    input  logic [PORTS*ADDR_W-1:0] req_addr,
    input  logic [PORTS*VW-1:0]   req_wdata,
    output logic [PORTS-1:0]      grant,
    output logic [PORTS-1:0]      rvalid,
    output logic [VW-1:0]         rdata,
    output logic [PORTS-1:0]      stall,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [VW-1:0]         mem_wdata,
    output logic                  mem_load,
    output logic                  mem_write,
    input  logic [VW-1:0]         mem_rdata
);

    import proc_pkg::*;

    arb_state_t       state, state_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [PORTS-1:0] win_q, win_d;
    logic [IW-1:0]    win_idx_q, win_idx_d;
    logic             op_q, op_d;

    logic [PORTS-1:0]  grant_d, rvalid_d;
    logic [VW-1:0]     rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              load_d, write_d;

    logic [PORTS-1:0]  pick_win;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic [ADDR_W-1:0] sel_addr;
    logic [VW-1:0]     sel_wdata;
    logic              sel_op;

    rr_picker #(.PORTS(PORTS)) u_picker (
        .req     (req_valid),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // One-hot mux of the winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_op    = OP_LOAD;
        for (int k = 0; k < PORTS; k++) begin
            if (pick_win[k]) begin
                sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[k*VW +: VW];
                sel_op    = req_write[k];
            end
        end
    end

    // Outputs are registered, so their _d values are what the next state shows:
    // grant/strobes are loaded on the IDLE->ACCESS edge, rvalid on WAIT->RESP.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        cnt_d     = cnt;
        win_d     = win_q;
        win_idx_d = win_idx_q;
        op_d      = op_q;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        rdata_d   = rdata;
        grant_d   = '0;
        rvalid_d  = '0;
        load_d    = 1'b0;
        write_d   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    win_d     = pick_win;
                    win_idx_d = pick_idx;
                    op_d      = sel_op;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    grant_d   = pick_win;
                    write_d   = (sel_op == OP_WRITE);
                    load_d    = (sel_op == OP_LOAD);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                ptr_d = IW'((int'(win_idx_q) + 1) % PORTS);
                if (op_q == OP_WRITE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CW'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = win_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            win_q     <= '0;
            win_idx_q <= '0;
            op_q      <= OP_LOAD;
            grant     <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_load  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            win_q     <= win_d;
            win_idx_q <= win_idx_d;
            op_q      <= op_d;
            grant     <= grant_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_load  <= load_d;
            mem_write <= write_d;
        end
    end

    // A write completes the cycle its grant is on the bus; a load completes on rvalid.
    for (genvar i = 0; i < PORTS; i++) begin : g_stall
        assign stall[i] = req_valid[i] & ~(grant[i] & op_q) & ~rvalid[i];
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int P  = 4;
    localparam int AW = 16;
    localparam int VW = 512;
    localparam logic [VW-1:0] GARB = {32{16'hBAD0}};

    logic clock = 1'b0;
    logic reset;

    logic [P-1:0]    req_valid, req_write, grant, rvalid, stall;
    logic [P*AW-1:0] req_addr;
    logic [P*VW-1:0] req_wdata;
    logic [VW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_load, mem_write;

    logic [P-1:0]    req_valid1, req_write1, grant1, rvalid1, stall1;
    logic [P*AW-1:0] req_addr1;
    logic [P*VW-1:0] req_wdata1;
    logic [VW-1:0]   rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0]   mem_addr1;
    logic            mem_load1, mem_write1;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.PORTS(P), .CORES(32), .BITS(16), .ADDR_W(AW), .MEM_LATENCY(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .rvalid(rvalid),
        .rdata(rdata), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_load(mem_load), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.PORTS(P), .CORES(32), .BITS(16), .ADDR_W(AW), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .grant(grant1), .rvalid(rvalid1),
        .rdata(rdata1), .stall(stall1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_load(mem_load1), .mem_write(mem_write1), .mem_rdata(mem_rdata1)
    );

    function automatic logic [VW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [VW-1:0] v;
        for (int k = 0; k < 32; k++) v[k*16 +: 16] = a + 16'(k) * 16'h0101;
        return v;
    endfunction

    function automatic logic [VW-1:0] wfn(input int p);
        logic [VW-1:0] v;
        for (int k = 0; k < 32; k++) v[k*16 +: 16] = 16'hA000 + 16'(p * 256 + k);
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int p);
        return 16'h1000 + 16'(p) * 16'h0110;
    endfunction

    // Memory models: data is on mem_rdata only during the one cycle the
    // latency says it is valid, garbage otherwise. Not reset with the DUT.
    logic [1:0]         lp;
    logic [1:0][AW-1:0] ap;
    logic               lp1;
    logic [AW-1:0]      ap1;
    always @(posedge clock) begin
        lp  <= {lp[0], mem_load};
        ap  <= {ap[0], mem_addr};
        lp1 <= mem_load1;
        ap1 <= mem_addr1;
    end
    assign mem_rdata  = (lp[1] === 1'b1) ? mem_fn(ap[1]) : GARB;
    assign mem_rdata1 = (lp1 === 1'b1) ? mem_fn(ap1) : GARB;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (grant !== 0 || rvalid !== 0) $display("FAIL reset_pulses: grant=%b rvalid=%b want 0", grant, rvalid); else passed++;
        checks++; if (mem_load !== 0 || mem_write !== 0) $display("FAIL reset_strobes: load=%b write=%b want 0", mem_load, mem_write); else passed++;
        checks++; if (mem_addr !== 0 || mem_wdata !== 0 || rdata !== 0) $display("FAIL reset_data: addr=%h wdata/rdata nonzero", mem_addr); else passed++;
        checks++; if (stall !== 0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
        checks++; if (grant1 !== 0 || rdata1 !== 0 || mem_addr1 !== 0) $display("FAIL reset_dut1: grant=%b addr=%h", grant1, mem_addr1); else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        step();
    endtask

    task automatic test_all_writes();
        logic [P-1:0] exp_stall;
        req_write = 4'hf;
        for (int p = 0; p < P; p++) begin
            req_addr[p*AW +: AW]  = addr_of(p);
            req_wdata[p*VW +: VW] = wfn(p);
        end
        req_valid = 4'hf;
        for (int i = 0; i < P; i++) begin
            step();
            checks++; if (grant !== 4'(1 << i)) $display("FAIL wr_grant%0d: got %b want %b", i, grant, 4'(1 << i)); else passed++;
            checks++; if (mem_write !== 1'b1 || mem_load !== 1'b0) $display("FAIL wr_strobe%0d: write=%b load=%b want 1/0", i, mem_write, mem_load); else passed++;
            checks++; if (mem_addr !== addr_of(i)) $display("FAIL wr_addr%0d: got %h want %h", i, mem_addr, addr_of(i)); else passed++;
            checks++; if (mem_wdata !== wfn(i)) $display("FAIL wr_wdata%0d: got %h want %h", i, mem_wdata, wfn(i)); else passed++;
            exp_stall = req_valid & ~4'(1 << i);
            checks++; if (stall !== exp_stall) $display("FAIL wr_stall%0d: got %b want %b", i, stall, exp_stall); else passed++;
            req_valid[i] = 1'b0;
            step();
            checks++; if (grant !== 0 || mem_write !== 0) $display("FAIL wr_gap%0d: grant=%b write=%b want 0", i, grant, mem_write); else passed++;
        end
    endtask

    task automatic test_fairness();
        req_write = 4'hf;
        req_valid = 4'hf;
        for (int t = 0; t < 2 * P; t++) begin
            step();
            checks++; if (grant !== 4'(1 << (t % P))) $display("FAIL fair_grant%0d: got %b want %b", t, grant, 4'(1 << (t % P))); else passed++;
            if (t == 2 * P - 1) req_valid = 4'h0;
            step();
            checks++; if (grant !== 0) $display("FAIL fair_gap%0d: got %b want 0", t, grant); else passed++;
        end
    endtask

    task automatic test_single_load();
        req_write = 4'h0;
        req_addr[2*AW +: AW] = 16'h0040;
        req_valid = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100 || mem_load !== 1'b1 || mem_write !== 1'b0) $display("FAIL ld_access: grant=%b load=%b write=%b want 0100/1/0", grant, mem_load, mem_write); else passed++;
        checks++; if (mem_addr !== 16'h0040) $display("FAIL ld_addr: got %h want 0040", mem_addr); else passed++;
        checks++; if (stall !== 4'b0100) $display("FAIL ld_stall_access: got %b want 0100", stall); else passed++;
        step();
        checks++; if (rvalid !== 0 || mem_load !== 0) $display("FAIL ld_wait1: rvalid=%b load=%b want 0", rvalid, mem_load); else passed++;
        step();
        checks++; if (rvalid !== 0) $display("FAIL ld_wait2: rvalid=%b want 0", rvalid); else passed++;
        step();
        checks++; if (rvalid !== 4'b0100) $display("FAIL ld_rvalid: got %b want 0100", rvalid); else passed++;
        checks++; if (rdata !== mem_fn(16'h0040)) $display("FAIL ld_rdata: got %h want %h", rdata, mem_fn(16'h0040)); else passed++;
        checks++; if (stall !== 0) $display("FAIL ld_stall_resp: got %b want 0", stall); else passed++;
        req_valid = 4'h0;
        step();
        checks++; if (rvalid !== 0 || rdata !== mem_fn(16'h0040)) $display("FAIL ld_hold: rvalid=%b rdata=%h", rvalid, rdata); else passed++;
    endtask

    task automatic test_load_blocks_write();
        req_write = 4'b1000;
        req_addr[0 +: AW] = 16'h0200;
        req_valid = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001 || mem_load !== 1'b1) $display("FAIL lw_access: grant=%b load=%b want 0001/1", grant, mem_load); else passed++;
        req_valid[3] = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            step();
            checks++; if (grant !== 0) $display("FAIL lw_nogrant_c%0d: got %b want 0", c, grant); else passed++;
            checks++; if (stall[3] !== 1'b1) $display("FAIL lw_stall3_c%0d: got %b want 1", c, stall[3]); else passed++;
            if (c == 4) begin
                checks++; if (rvalid !== 4'b0001) $display("FAIL lw_rvalid: got %b want 0001", rvalid); else passed++;
                checks++; if (rdata !== mem_fn(16'h0200)) $display("FAIL lw_rdata: got %h want %h", rdata, mem_fn(16'h0200)); else passed++;
                req_valid[0] = 1'b0;
            end
        end
        step();
        checks++; if (grant !== 4'b1000 || mem_write !== 1'b1) $display("FAIL lw_grant3: grant=%b write=%b want 1000/1", grant, mem_write); else passed++;
        checks++; if (mem_addr !== addr_of(3) || mem_wdata !== wfn(3)) $display("FAIL lw_bus3: addr=%h want %h", mem_addr, addr_of(3)); else passed++;
        checks++; if (stall[3] !== 1'b0) $display("FAIL lw_stall3_done: got %b want 0", stall[3]); else passed++;
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_reset_mid();
        req_write = 4'h0;
        req_addr[2*AW +: AW] = 16'h0777;
        req_valid = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100) $display("FAIL rm_grant: got %b want 0100", grant); else passed++;
        step();
        reset = 1'b1;
        req_valid = 4'h0;
        #1;
        checks++; if (grant !== 0 || rvalid !== 0 || mem_load !== 0 || mem_write !== 0) $display("FAIL rm_async_ctl: grant=%b rvalid=%b load=%b write=%b", grant, rvalid, mem_load, mem_write); else passed++;
        checks++; if (mem_addr !== 0 || mem_wdata !== 0 || rdata !== 0) $display("FAIL rm_async_data: addr=%h want 0", mem_addr); else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (rvalid !== 0 || rdata !== 0) $display("FAIL rm_late%0d: rvalid=%b rdata=%h want 0", c, rvalid, rdata); else passed++;
        end
        req_write = 4'b1010;
        req_valid = 4'b1010;
        step();
        checks++; if (grant !== 4'b0010 || mem_addr !== addr_of(1)) $display("FAIL rm_ptr0: grant=%b addr=%h want 0010/%h", grant, mem_addr, addr_of(1)); else passed++;
        req_valid[1] = 1'b0;
        step();
        step();
        checks++; if (grant !== 4'b1000) $display("FAIL rm_next: got %b want 1000", grant); else passed++;
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_latency1();
        req_write1 = 4'h0;
        req_addr1[0 +: AW] = 16'h0123;
        req_valid1 = 4'b0001;
        step();
        checks++; if (grant1 !== 4'b0001 || mem_load1 !== 1'b1) $display("FAIL l1_access: grant=%b load=%b want 0001/1", grant1, mem_load1); else passed++;
        step();
        checks++; if (rvalid1 !== 0) $display("FAIL l1_wait: rvalid=%b want 0", rvalid1); else passed++;
        step();
        checks++; if (rvalid1 !== 4'b0001) $display("FAIL l1_rvalid: got %b want 0001", rvalid1); else passed++;
        checks++; if (rdata1 !== mem_fn(16'h0123)) $display("FAIL l1_rdata: got %h want %h", rdata1, mem_fn(16'h0123)); else passed++;
        req_valid1 = 4'h0;
        step();
        checks++; if (rvalid1 !== 0) $display("FAIL l1_after: rvalid=%b want 0", rvalid1); else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0; req_write  = '0; req_addr  = '0; req_wdata  = '0;
        req_valid1 = '0; req_write1 = '0; req_addr1 = '0; req_wdata1 = '0;
        test_reset();
        test_all_writes();
        test_fairness();
        test_single_load();
        test_load_blocks_write();
        test_reset_mid();
        test_latency1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
